// File: rtl/mac_mdc_tcdm_responder.sv
// Banked, word-interleaved TCDM slave model with per-bank round-robin arbitration,
// one-cycle read latency and optional LFSR-driven grant stalling.
`default_nettype none

module mac_mdc_tcdm_responder #(
  parameter int          MP         = 4,
  parameter int          NB         = 4,
  parameter int          BANK_WORDS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [MP-1:0]    tcdm_req,
  output logic [MP-1:0]    tcdm_gnt,
  input  logic [MP*32-1:0] tcdm_add,
  input  logic [MP-1:0]    tcdm_wen,
  input  logic [MP*4-1:0]  tcdm_be,
  input  logic [MP*32-1:0] tcdm_data,
  output logic [MP*32-1:0] tcdm_r_data,
  output logic [MP-1:0]    tcdm_r_valid,
  input  logic             stall_en_i,
  output logic             err_o,
  output logic [31:0]      gnt_cnt_o
);

  localparam int          BW        = $clog2(NB);
  localparam int          RW        = $clog2(BANK_WORDS);
  localparam int          AW        = BW + RW;
  localparam int          PW        = (MP > 1) ? $clog2(MP) : 1;
  localparam int          NG        = NB + 1;
  localparam int          GW        = $clog2(NG);
  localparam logic [31:0] WIN_BYTES = 32'(NB * BANK_WORDS * 4);
  localparam logic [31:0] OOW_DATA  = 32'hDEAD_BEEF;

  logic [31:0]   mem [NB*BANK_WORDS];
  logic [31:0]   off [MP];
  logic [AW-1:0] widx [MP];
  logic [GW-1:0] grp [MP];
  logic [MP-1:0] in_win;

  logic [PW-1:0] rr_ptr [NG];
  logic [PW-1:0] grp_win [NG];
  logic [NG-1:0] grp_hit;
  logic [MP-1:0] win;
  logic [15:0]   lfsr;
  logic          stall;
  logic [31:0]   gnt_sum;
  logic          oow_gnt;
  logic [31:0]   r_data [MP];
  logic [MP-1:0] r_valid;
  logic          err;
  logic [31:0]   gnt_cnt;
  int            idx;

  // Out-of-window ports are placed in group NB so they arbitrate among themselves.
  always_comb begin
    for (int p = 0; p < MP; p++) begin
      off[p]    = tcdm_add[p*32 +: 32] - BASE_ADDR;
      in_win[p] = (tcdm_add[p*32 +: 32] >= BASE_ADDR) && (off[p] < WIN_BYTES);
      widx[p]   = off[p][2 +: AW];
      grp[p]    = in_win[p] ? GW'(off[p][2 +: BW]) : GW'(NB);
    end
  end

  always_comb begin
    win     = '0;
    grp_hit = '0;
    idx     = 0;
    for (int g = 0; g < NG; g++) grp_win[g] = '0;
    for (int g = 0; g < NG; g++) begin
      for (int k = 0; k < MP; k++) begin
        idx = (int'(rr_ptr[g]) + k) % MP;
        if (!grp_hit[g] && tcdm_req[idx] && (grp[idx] == GW'(g))) begin
          grp_hit[g] = 1'b1;
          grp_win[g] = PW'(idx);
          win[idx]   = 1'b1;
        end
      end
    end
  end

  assign stall    = stall_en_i & lfsr[0];
  assign tcdm_gnt = (rst_i || stall) ? '0 : win;
  assign oow_gnt  = |(tcdm_gnt & ~in_win);

  always_comb begin
    gnt_sum = '0;
    for (int p = 0; p < MP; p++) gnt_sum = gnt_sum + 32'(tcdm_gnt[p]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr    <= 16'hACE1;
      gnt_cnt <= '0;
      err     <= 1'b0;
      r_valid <= '0;
      for (int p = 0; p < MP; p++) r_data[p] <= '0;
      for (int g = 0; g < NG; g++) rr_ptr[g] <= '0;
    end else begin
      lfsr    <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      gnt_cnt <= gnt_cnt + gnt_sum;
      if (oow_gnt) err <= 1'b1;
      r_valid <= tcdm_gnt;
      for (int p = 0; p < MP; p++) begin
        if (tcdm_gnt[p]) begin
          if (!tcdm_wen[p])    r_data[p] <= '0;
          else if (in_win[p])  r_data[p] <= mem[widx[p]];
          else                 r_data[p] <= OOW_DATA;
        end
      end
      for (int g = 0; g < NG; g++) begin
        if (grp_hit[g] && !stall)
          rr_ptr[g] <= (grp_win[g] == PW'(MP - 1)) ? '0 : grp_win[g] + 1'b1;
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < MP; p++) begin
      if (tcdm_gnt[p] && !tcdm_wen[p] && in_win[p]) begin
        for (int b = 0; b < 4; b++) begin
          if (tcdm_be[p*4 + b]) mem[widx[p]][b*8 +: 8] <= tcdm_data[p*32 + b*8 +: 8];
        end
      end
    end
  end

  // A response in flight when reset arrives is hidden immediately, not one cycle later.
  always_comb begin
    for (int p = 0; p < MP; p++) tcdm_r_data[p*32 +: 32] = rst_i ? 32'h0 : r_data[p];
  end

  assign tcdm_r_valid = r_valid & ~{MP{rst_i}};
  assign err_o        = err;
  assign gnt_cnt_o    = gnt_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mac_mdc_tcdm_responder.sv
// Self-checking bench: vector table of grants plus a response scoreboard
// backed by a reference memory and an independent stall LFSR model.
`default_nettype none

module tb_mac_mdc_tcdm_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic [3:0]   req = '0;
  logic [3:0]   wen = '0;
  logic [15:0]  be = '0;
  logic [127:0] add = '0;
  logic [127:0] data = '0;
  logic         stall_en = 1'b0;
  logic [3:0]   gnt;
  logic [3:0]   r_valid;
  logic [127:0] r_data;
  logic         err;
  logic [31:0]  gnt_cnt;

  mac_mdc_tcdm_responder #(
    .MP(4), .NB(4), .BANK_WORDS(256), .BASE_ADDR(BASE)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .tcdm_req     (req),
    .tcdm_gnt     (gnt),
    .tcdm_add     (add),
    .tcdm_wen     (wen),
    .tcdm_be      (be),
    .tcdm_data    (data),
    .tcdm_r_data  (r_data),
    .tcdm_r_valid (r_valid),
    .stall_en_i   (stall_en),
    .err_o        (err),
    .gnt_cnt_o    (gnt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         stall;
    logic [3:0]   req;
    logic [3:0]   wen;
    logic [15:0]  be;
    logic [127:0] add;
    logic [127:0] data;
    logic [3:0]   exp_gnt;
  } vec_t;

  typedef struct {
    int          port;
    logic [31:0] data;
  } rsp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  exp_gnt = '0;
  logic [3:0]  pend = '0;
  logic [31:0] cnt_m = '0;
  logic        err_m = 1'b0;
  logic [31:0] last [4];
  logic [31:0] mmem [int];
  logic [15:0] lfsr_m = 16'hACE1;
  rsp_t        sb[$];
  vec_t        tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v.rst = 1'b0; v.stall = 1'b0; v.req = '0; v.wen = '0; v.be = '0;
    v.add = '0; v.data = '0; v.exp_gnt = '0;
    return v;
  endfunction

  function automatic vec_t acc(input vec_t vin, input int p, input logic w,
                               input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    vec_t v = vin;
    v.req[p]         = 1'b1;
    v.wen[p]         = w;
    v.be[p*4 +: 4]   = b;
    v.add[p*32 +: 32] = a;
    v.data[p*32 +: 32] = d;
    return v;
  endfunction

  function automatic vec_t one(input int p, input logic w, input logic [3:0] b,
                               input logic [31:0] a, input logic [31:0] d, input logic [3:0] eg);
    vec_t v = acc(idle(), p, w, b, a, d);
    v.exp_gnt = eg;
    return v;
  endfunction

  function automatic logic in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h1000);
  endfunction

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst_i    = v.rst;
    stall_en = v.stall;
    req      = v.req;
    wen      = v.wen;
    be       = v.be;
    add      = v.add;
    data     = v.data;
    exp_gnt  = (v.rst || (v.stall && lfsr_m[0])) ? 4'b0 : v.exp_gnt;
  endtask

  // Independent stall reference: 16-bit Fibonacci LFSR, taps 16,14,13,11.
  always @(posedge clk) begin
    if (rst_i) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  always @(negedge clk) begin
    if (rst_i) begin
      chk("gnt_in_reset", 32'(gnt), 32'h0);
      chk("rvalid_in_reset", 32'(r_valid), 32'h0);
      pend  = '0;
      sb.delete();
      cnt_m = '0;
      err_m = 1'b0;
      for (int p = 0; p < 4; p++) last[p] = '0;
    end else begin
      logic        err_n;
      logic [31:0] a;
      logic [31:0] ed;
      int          k;
      rsp_t        e;
      err_n = err_m;
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("gnt_cnt", gnt_cnt, cnt_m);
      chk("err", 32'(err), 32'(err_m));
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("rvalid_p%0d", p), 32'(r_valid[p]), 32'(pend[p]));
        if (pend[p]) begin
          if (sb.size() == 0) begin
            chk($sformatf("sb_empty_p%0d", p), 32'h1, 32'h0);
          end else begin
            e = sb.pop_front();
            chk($sformatf("sb_port_p%0d", p), 32'(e.port), 32'(p));
            last[p] = e.data;
          end
        end
        chk($sformatf("rdata_p%0d", p), r_data[p*32 +: 32], last[p]);
      end
      for (int p = 0; p < 4; p++) begin
        if (exp_gnt[p]) begin
          a = add[p*32 +: 32];
          k = int'((a - BASE) >> 2);
          if (!in_win(a)) err_n = 1'b1;
          if (wen[p]) begin
            ed = in_win(a) ? mmem[k] : 32'hDEAD_BEEF;
          end else begin
            ed = 32'h0;
            if (in_win(a)) begin
              if (!mmem.exists(k)) mmem[k] = 32'h0;
              for (int b = 0; b < 4; b++)
                if (be[p*4 + b]) mmem[k][b*8 +: 8] = data[p*32 + b*8 +: 8];
            end
          end
          e.port = p;
          e.data = ed;
          sb.push_back(e);
        end
      end
      pend  = exp_gnt;
      cnt_m = cnt_m + 32'(exp_gnt[0]) + 32'(exp_gnt[1]) + 32'(exp_gnt[2]) + 32'(exp_gnt[3]);
      err_m = err_n;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   i;
    int   guard;

    // Reset with requests present: grants must stay low.
    v = idle(); v.rst = 1'b1; v.req = 4'hF; v.wen = 4'hF;
    for (int c = 0; c < 3; c++) tbl.push_back(v);
    tbl.push_back(idle());
    tbl.push_back(one(0, 1'b0, 4'hF, BASE + 32'h10, 32'hCAFE_F00D, 4'b0001));
    tbl.push_back(one(0, 1'b1, 4'h0, BASE + 32'h10, 32'h0, 4'b0001));
    tbl.push_back(one(0, 1'b0, 4'hF, BASE + 32'h20, 32'h1122_3344, 4'b0001));
    tbl.push_back(one(0, 1'b0, 4'b0101, BASE + 32'h20, 32'hAABB_CCDD, 4'b0001));
    tbl.push_back(one(0, 1'b1, 4'h0, BASE + 32'h20, 32'h0, 4'b0001));
    // Bank-0 grants by p2 then p3 leave the bank-0 pointer back at p0.
    tbl.push_back(one(2, 1'b0, 4'hF, BASE + 32'h00, 32'hA5A5_A5A5, 4'b0100));
    tbl.push_back(one(3, 1'b0, 4'hF, BASE + 32'h30, 32'h3333_3333, 4'b1000));
    for (int c = 0; c < 5; c++) begin
      v = idle();
      for (int p = 0; p < 4; p++) v = acc(v, p, 1'b1, 4'h0, BASE + 32'(p * 16), 32'h0);
      v.exp_gnt = 4'b0001 << (c % 4);
      tbl.push_back(v);
    end
    v = idle();
    v = acc(v, 0, 1'b0, 4'hF, BASE + 32'h40, 32'h4040_4040);
    v = acc(v, 1, 1'b0, 4'hF, BASE + 32'h04, 32'h4444_0004);
    v = acc(v, 2, 1'b0, 4'hF, BASE + 32'h08, 32'h8888_0008);
    v = acc(v, 3, 1'b0, 4'hF, BASE + 32'h0C, 32'hCCCC_000C);
    v.exp_gnt = 4'hF;
    tbl.push_back(v);
    for (int c = 0; c < 3; c++) begin
      v = idle();
      for (int p = 0; p < 4; p++) v = acc(v, p, 1'b1, 4'h0, BASE + 32'(p * 4), 32'h0);
      v.exp_gnt = 4'hF;
      tbl.push_back(v);
    end
    tbl.push_back(one(2, 1'b1, 4'h0, BASE - 32'h4, 32'h0, 4'b0100));
    tbl.push_back(one(1, 1'b0, 4'hF, BASE + 32'h1000, 32'hFFFF_FFFF, 4'b0010));
    tbl.push_back(one(0, 1'b1, 4'h0, BASE + 32'h00, 32'h0, 4'b0001));
    tbl.push_back(idle());
    tbl.push_back(idle());
    // Ramp preload: each cycle the four ports hit four distinct banks.
    for (int c = 0; c < 16; c++) begin
      v = idle();
      for (int p = 0; p < 4; p++)
        v = acc(v, p, 1'b0, 4'hF, BASE + 32'h100 + 32'(c * 16 + p * 4), 32'h5A00_0000 + 32'(c * 4 + p));
      v.exp_gnt = 4'hF;
      tbl.push_back(v);
    end

    for (int n = 0; n < tbl.size(); n++) apply(tbl[n]);

    // Stall: p0 streams 64 reads, holding each request until the model says it is granted.
    i = 0;
    guard = 0;
    while (i < 64 && guard < 1000) begin
      v = one(0, 1'b1, 4'h0, BASE + 32'h100 + 32'(i * 4), 32'h0, 4'b0001);
      v.stall = 1'b1;
      apply(v);
      if (exp_gnt[0]) i++;
      guard++;
    end
    chk("stall_stream_done", 32'(i), 32'd64);
    apply(idle());

    // Reset in the cycle after a granted write.
    apply(one(0, 1'b0, 4'hF, BASE + 32'h80, 32'h7777_7777, 4'b0001));
    v = one(0, 1'b1, 4'h0, BASE + 32'h80, 32'h0, 4'b0000);
    v.rst = 1'b1;
    apply(v);
    apply(v);
    apply(idle());
    v = idle();
    v = acc(v, 0, 1'b1, 4'h0, BASE + 32'h80, 32'h0);
    v = acc(v, 1, 1'b1, 4'h0, BASE + 32'h04, 32'h0);
    v.exp_gnt = 4'b0011;
    apply(v);
    apply(idle());
    apply(idle());
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
